// File: rtl/requant_relu.sv
// Output stage after the residual adder: optional ReLU, rounding right shift,
// saturation to BITWIDTH signed, 2-stage valid/ready pipeline, saturation counter.
`ifndef BITWIDTH
`define BITWIDTH 8
`endif
`ifndef BW_FL
`define BW_FL 5
`endif

module requant_relu #(
  parameter int unsigned GROUP_CHANNEL = 16,
  parameter int unsigned BW_RELU       = 2 * `BITWIDTH + 4 + $clog2(GROUP_CHANNEL) + 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic signed [BW_RELU-1:0]   res_in,
  input  logic                        relu,
  input  logic [`BW_FL-1:0]           shift,
  input  logic                        in_last,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic signed [`BITWIDTH-1:0] out_data,
  output logic                        out_last,
  input  logic                        sat_clr,
  output logic [15:0]                 sat_cnt
);

  localparam int unsigned BW_Q   = BW_RELU + 1;
  localparam int unsigned BW_OUT = `BITWIDTH;
  localparam int unsigned BW_SH  = `BW_FL;

  localparam logic signed [BW_Q-1:0]   Q_MAX   = BW_Q'((1 << (BW_OUT - 1)) - 1);
  localparam logic signed [BW_Q-1:0]   Q_MIN   = BW_Q'(-(1 << (BW_OUT - 1)));
  localparam logic signed [BW_OUT-1:0] OUT_MAX = BW_OUT'((1 << (BW_OUT - 1)) - 1);
  localparam logic signed [BW_OUT-1:0] OUT_MIN = BW_OUT'(-(1 << (BW_OUT - 1)));
  localparam logic [BW_SH-1:0]         SH_CAP  = BW_SH'(BW_RELU);

  logic signed [BW_RELU-1:0] r;
  logic signed [BW_Q-1:0]    r_ext;
  logic signed [BW_Q-1:0]    rnd;
  logic signed [BW_Q-1:0]    sum;
  logic signed [BW_Q-1:0]    q;
  logic                      q_ovf;
  logic [BW_SH-1:0]          sh_eff;

  logic                      s1_valid;
  logic signed [BW_Q-1:0]    s1_q;
  logic                      s1_ovf;
  logic                      s1_last;
  logic signed [BW_OUT-1:0]  sat_data;

  logic                      s1_load;
  logic                      s2_load;

  assign in_ready = !s1_valid || !out_valid || out_ready;
  assign s1_load  = in_valid && in_ready;
  assign s2_load  = s1_valid && (!out_valid || out_ready);

  // Shifts past BW_RELU give the same exact result as BW_RELU (always 0), so cap them
  // to keep the rounding constant representable in BW_RELU+1 bits.
  always_comb begin
    r = res_in;
    if (relu && res_in[BW_RELU-1]) r = '0;
    r_ext  = {r[BW_RELU-1], r};
    sh_eff = shift;
    if (32'(shift) > BW_RELU) sh_eff = SH_CAP;
    rnd = '0;
    if (sh_eff != '0) rnd = BW_Q'(1) << (sh_eff - BW_SH'(1));
    sum   = r_ext + rnd;
    q     = sum >>> sh_eff;
    q_ovf = (q > Q_MAX) || (q < Q_MIN);
  end

  // Clamp the stage-1 value into the output range.
  always_comb begin
    sat_data = s1_q[BW_OUT-1:0];
    if (s1_q > Q_MAX)      sat_data = OUT_MAX;
    else if (s1_q < Q_MIN) sat_data = OUT_MIN;
  end

  // Stage 1 register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_q     <= '0;
      s1_ovf   <= 1'b0;
      s1_last  <= 1'b0;
    end else if (s1_load) begin
      s1_valid <= 1'b1;
      s1_q     <= q;
      s1_ovf   <= q_ovf;
      s1_last  <= in_last;
    end else if (s2_load) begin
      s1_valid <= 1'b0;
    end
  end

  // Stage 2 (output) register; data is kept after a drain.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
    end else if (s2_load) begin
      out_valid <= 1'b1;
      out_data  <= sat_data;
      out_last  <= s1_last;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Saturation-event counter, sticky at all-ones; clear wins over increment.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sat_cnt <= '0;
    end else if (sat_clr) begin
      sat_cnt <= '0;
    end else if (s2_load && s1_ovf && (sat_cnt != 16'hFFFF)) begin
      sat_cnt <= sat_cnt + 16'd1;
    end
  end

endmodule
